rr_arb8_enc: RTL

Eight-requester round-robin arbiter that shares one resource among eight clients and reports the winner both one-hot and as a 3-bit encoded index, the same 8-to-3 encoding used by the combinational encoder blocks. It sits between the requesting blocks and the shared resource. It holds a grant until the owner releases it or a hold-time limit expires while other clients are waiting. Fairness comes from a rotating priority pointer.

---
 rtl/rr_arb8_enc.sv | 107 ++++++++++
 1 files changed

// File: rtl/rr_arb8_enc.sv
// Eight-requester round-robin arbiter with hold-time preemption.
// Reports the winner one-hot (gnt) and encoded (gnt_idx); all outputs registered.
module rr_arb8_enc #(
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       busy,
  output logic       preempt
);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] owner_q, owner_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] gnt_idx_q, gnt_idx_d;
  logic       preempt_q, preempt_d;

  logic       sel_found;
  logic [2:0] sel_idx;
  logic [2:0] cand;
  logic       timeout;

  // Rotating priority scan: first set request at ptr, ptr+1, ... (mod 8).
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int i = 0; i < 8; i++) begin
      cand = ptr_q + 3'(i);
      if (!sel_found && req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  assign timeout = (HOLD_LIM != 8'd0) && (hold_cnt_q >= HOLD_LIM) && ((req & ~gnt_q) != 8'd0);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    hold_cnt_d = hold_cnt_q;
    gnt_d      = gnt_q;
    gnt_idx_d  = gnt_idx_q;
    preempt_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          gnt_d      = 8'b1 << sel_idx;
          gnt_idx_d  = sel_idx;
          owner_d    = sel_idx;
          hold_cnt_d = 8'd1;
          state_d    = S_GRANT;
        end
      end
      S_GRANT: begin
        if (!req[owner_q] || timeout) begin
          gnt_d     = 8'd0;
          gnt_idx_d = 3'd0;
          ptr_d     = owner_q + 3'd1;
          state_d   = S_IDLE;
          // A simultaneous release wins over the timeout, so no pulse then.
          preempt_d = req[owner_q];
        end else if (hold_cnt_q != 8'hFF) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= 3'd0;
      owner_q    <= 3'd0;
      hold_cnt_q <= 8'd0;
      gnt_q      <= 8'd0;
      gnt_idx_q  <= 3'd0;
      preempt_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_q      <= gnt_d;
      gnt_idx_q  <= gnt_idx_d;
      preempt_q  <= preempt_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = gnt_idx_q;
  assign busy    = |gnt_q;
  assign preempt = preempt_q;

endmodule
